lfsr_stream_arbiter: RTL

Shares one 4-bit Fibonacci LFSR keystream engine between two requesters. The block runs a round-robin grant, loads the winner's seed and discards a per-request number of warm-up rounds. It then serialises WORD_W keystream bits into a packed word and returns that word on a valid/ready handshake tagged with the requester id. It sits between the cipher front-ends and the keystream core and owns all sequencing of that core.

---
 rtl/lfsr_stream_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/lfsr_stream_arbiter.sv
// Round-robin arbiter sharing one 4-bit Fibonacci LFSR keystream engine between two requesters.
// Optional macro LFSR_ABORT_EN adds an abort input that cancels a job in LOAD, WARM or GEN.
module lfsr_stream_arbiter #(
  parameter int          WORD_W       = 16,
  parameter int          CNT_W        = 5,
  parameter logic [3:0]  DEFAULT_SEED = 4'b1110
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req,
  input  logic [3:0]        seed0,
  input  logic [3:0]        seed1,
  input  logic [CNT_W-1:0]  warm0,
  input  logic [CNT_W-1:0]  warm1,
`ifdef LFSR_ABORT_EN
  input  logic              abort,
`endif
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              out_valid,
  output logic              out_id,
  output logic [WORD_W-1:0] out_word,
  input  logic              out_ready
);

  localparam int BW = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [BW-1:0]    BIT_ONE = BW'(1);

  typedef enum logic [2:0] {IDLE, LOAD, WARM, GEN, HOLD} state_t;

  typedef struct packed {
    logic [3:0]       seed;
    logic [CNT_W-1:0] warm;
  } job_t;

  state_t          state;
  logic [3:0]      s;
  logic [CNT_W-1:0] cnt;
  logic [BW-1:0]   bit_cnt;
  job_t            job;
  logic            rr_ptr_last;
  logic            win;
  logic            abort_hit;

  function automatic logic [3:0] lfsr_step(input logic [3:0] v);
    return {v[3] ^ v[2] ^ v[0], v[3:1]};
  endfunction

`ifdef LFSR_ABORT_EN
  assign abort_hit = abort && (state == LOAD || state == WARM || state == GEN);
`else
  assign abort_hit = 1'b0;
`endif

  // On a tie the requester that was not served last wins.
  always_comb begin
    win = 1'b0;
    if (req == 2'b10)      win = 1'b1;
    else if (req == 2'b11) win = ~rr_ptr_last;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      s           <= DEFAULT_SEED;
      cnt         <= '0;
      bit_cnt     <= '0;
      job         <= '0;
      rr_ptr_last <= 1'b1;
      gnt         <= 2'b00;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_id      <= 1'b0;
      out_word    <= '0;
    end else if (abort_hit) begin
      state       <= IDLE;
      gnt         <= 2'b00;
      busy        <= 1'b0;
      rr_ptr_last <= out_id;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            state    <= LOAD;
            busy     <= 1'b1;
            gnt      <= win ? 2'b10 : 2'b01;
            out_id   <= win;
            job.seed <= win ? seed1 : seed0;
            job.warm <= win ? warm1 : warm0;
          end
        end
        LOAD: begin
          // An all-zero seed would lock the LFSR, so substitute the default.
          s       <= (job.seed == 4'b0000) ? DEFAULT_SEED : job.seed;
          cnt     <= job.warm;
          bit_cnt <= BW'(WORD_W);
          state   <= (job.warm != '0) ? WARM : GEN;
        end
        WARM: begin
          s   <= lfsr_step(s);
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= GEN;
        end
        GEN: begin
          out_word <= {out_word[WORD_W-2:0], s[0]};
          s        <= lfsr_step(s);
          bit_cnt  <= bit_cnt - BIT_ONE;
          if (bit_cnt == BIT_ONE) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            gnt         <= 2'b00;
            rr_ptr_last <= out_id;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
